rll_key_loader: RTL and testbench

- Sequential key-delivery block for the RLL-locked combinational netlists (32 key inputs keyIn_0_0..keyIn_0_31).
- Receives the key serially from the secure key store over a valid/ready bit stream and assembles it in a shadow register.
- Drives the locked netlist's key inputs as one parallel word, updated atomically, so the netlist never sees a partial key.

---
 rtl/rll_key_loader.sv | 148 ++++++++++++++
 tb/tb_rll_key_loader.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/rll_key_loader.sv
// rll_key_loader
//   Serial-to-parallel key delivery for RLL-locked netlists. Key bits arrive
//   LSB first over a valid/ready stream. They are collected in a shadow
//   register. The shadow register is copied to key_out in one edge, so the
//   locked netlist never sees a partially loaded key.
//
//   Optional feature: define RLL_KEY_PARITY_EN to add one trailing even-parity
//   beat. The XOR of all KEY_W+1 beats must be 0, otherwise the commit fails
//   and err is raised.
//
// Ports
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   load_start   single-cycle request to start a key load
//   zeroize      wipes all key state (priority just below reset)
//   s_valid      serial key bit valid
//   s_bit        serial key bit, LSB first
//   s_ready      loader accepts a bit this cycle (SHIFT only)
//   key_out      committed key; bit i drives keyIn_0_i
//   key_applied  key_out holds a successfully committed key
//   load_done    one-cycle pulse on a successful commit
//   busy         high in SHIFT or COMMIT
//   err          sticky timeout / parity error
module rll_key_loader #(
  parameter int KEY_W       = 32,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_start,
  input  logic             zeroize,
  input  logic             s_valid,
  input  logic             s_bit,
  output logic             s_ready,
  output logic [KEY_W-1:0] key_out,
  output logic             key_applied,
  output logic             load_done,
  output logic             busy,
  output logic             err
);

  localparam int CNT_W = $clog2(KEY_W + 2);
  localparam int TO_W  = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam int IDX_W = (KEY_W > 1) ? $clog2(KEY_W) : 1;
`ifdef RLL_KEY_PARITY_EN
  localparam int BEATS = KEY_W + 1;
`else
  localparam int BEATS = KEY_W;
`endif

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  state_t             state, state_n;
  logic [KEY_W-1:0]   shadow;
  logic [CNT_W-1:0]   cnt;
  logic [TO_W-1:0]    to_cnt;
  logic               beat, last_beat, to_hit, commit_ok;
`ifdef RLL_KEY_PARITY_EN
  logic               par;   // running XOR of every accepted beat
`endif

  always_comb begin
    s_ready   = (state == SHIFT);
    busy      = (state != IDLE);
    beat      = s_valid && s_ready;
    last_beat = beat && (cnt == CNT_W'(BEATS - 1));
    // Fire on the idle cycle that would bring the counter to TIMEOUT_CYC.
    to_hit    = (TIMEOUT_CYC > 0) && (state == SHIFT) && !beat &&
                (to_cnt == TO_W'(TIMEOUT_CYC - 1));
`ifdef RLL_KEY_PARITY_EN
    commit_ok = !par;
`else
    commit_ok = 1'b1;
`endif

    state_n = state;
    case (state)
      IDLE:    if (load_start) state_n = SHIFT;
      SHIFT:   if (last_beat) state_n = COMMIT;
               else if (to_hit) state_n = IDLE;
      COMMIT:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (zeroize) state_n = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || zeroize) begin
      key_out     <= '0;
      shadow      <= '0;
      key_applied <= 1'b0;
      load_done   <= 1'b0;
      err         <= 1'b0;
      cnt         <= '0;
      to_cnt      <= '0;
`ifdef RLL_KEY_PARITY_EN
      par         <= 1'b0;
`endif
    end else begin
      load_done <= 1'b0;
      case (state)
        IDLE: if (load_start) begin
          // key_out and key_applied keep the previous key during a reload.
          cnt    <= '0;
          to_cnt <= '0;
          shadow <= '0;
          err    <= 1'b0;
`ifdef RLL_KEY_PARITY_EN
          par    <= 1'b0;
`endif
        end
        SHIFT: begin
          if (beat) begin
            // The parity beat (cnt == KEY_W) only feeds the XOR.
            if (cnt < CNT_W'(KEY_W)) shadow[cnt[IDX_W-1:0]] <= s_bit;
`ifdef RLL_KEY_PARITY_EN
            par    <= par ^ s_bit;
`endif
            cnt    <= cnt + 1'b1;
            to_cnt <= '0;
          end else if (TIMEOUT_CYC > 0) begin
            to_cnt <= to_cnt + 1'b1;
            if (to_hit) begin
              err    <= 1'b1;
              shadow <= '0;
            end
          end
        end
        COMMIT: begin
          if (commit_ok) begin
            key_out     <= shadow;
            key_applied <= 1'b1;
            load_done   <= 1'b1;
          end else begin
            err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rll_key_loader.sv
// Directed testbench for rll_key_loader (TIMEOUT_CYC=16, KEY_W=32).
// Inputs are driven and outputs are sampled on the falling edge.
module tb_rll_key_loader;

  logic        clk = 1'b0;
  logic        rst_n, load_start, zeroize, s_valid, s_bit;
  logic        s_ready, key_applied, load_done, busy, err;
  logic [31:0] key_out;

  int n_cmp = 0;
  int n_err = 0;
  logic hold_ok;

  rll_key_loader #(.KEY_W(32), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst_n(rst_n), .load_start(load_start), .zeroize(zeroize),
    .s_valid(s_valid), .s_bit(s_bit), .s_ready(s_ready), .key_out(key_out),
    .key_applied(key_applied), .load_done(load_done), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Stream the first n bits of k, LSB first. After every 4th bit, insert
  // gap idle cycles. While streaming, also watch that key_out stays at prior.
  task automatic stream_bits(input logic [31:0] k, input int n, input int gap,
                             input logic [31:0] prior);
    for (int i = 0; i < n; i++) begin
      s_valid = 1'b1;
      s_bit   = k[i];
      @(negedge clk);
      if (key_out !== prior) hold_ok = 1'b0;
      if (gap > 0 && (i % 4) == 3 && i != 31) begin
        s_valid = 1'b0;
        repeat (gap) begin
          @(negedge clk);
          if (key_out !== prior) hold_ok = 1'b0;
        end
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
  endtask

  // Run a full load. The task returns in the COMMIT cycle.
  task automatic load_key(input logic [31:0] k, input logic p, input int gap,
                          input logic [31:0] prior);
    hold_ok = 1'b1;
    pulse_start();
    chk1("shift_ready", s_ready, 1'b1);
    stream_bits(k, 32, gap, prior);
`ifdef RLL_KEY_PARITY_EN
    s_valid = 1'b1;
    s_bit   = p;
    @(negedge clk);
    s_valid = 1'b0;
`else
    s_bit = p;
`endif
    chk1("hold_key", hold_ok, 1'b1);
    chk32("commit_key_hold", key_out, prior);
    chk1("commit_ready", s_ready, 1'b0);
    chk1("commit_busy", busy, 1'b1);
    chk1("commit_no_done", load_done, 1'b0);
  endtask

  task automatic expect_commit(input logic [31:0] k);
    @(negedge clk);
    chk32("key_out", key_out, k);
    chk1("load_done", load_done, 1'b1);
    chk1("key_applied", key_applied, 1'b1);
    chk1("idle_busy", busy, 1'b0);
    chk1("err_clear", err, 1'b0);
    @(negedge clk);
    chk1("done_pulse", load_done, 1'b0);
  endtask

  task automatic do_zeroize();
    zeroize = 1'b1;
    @(negedge clk);
    zeroize = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; load_start = 1'b0; zeroize = 1'b0; s_valid = 1'b0; s_bit = 1'b0;
    hold_ok = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    // Reset state
    chk32("rst_key", key_out, 32'h0);
    chk1("rst_applied", key_applied, 1'b0);
    chk1("rst_done", load_done, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_err", err, 1'b0);
    chk1("rst_ready", s_ready, 1'b0);

    // Basic load, no gaps
    load_key(32'hA5A53C3C, ^32'hA5A53C3C, 0, 32'h0);
    expect_commit(32'hA5A53C3C);

    // Gapped load after zeroize: key_out holds 0 until the commit
    do_zeroize();
    chk32("zero_key", key_out, 32'h0);
    chk1("zero_applied", key_applied, 1'b0);
    load_key(32'hA5A53C3C, ^32'hA5A53C3C, 3, 32'h0);
    expect_commit(32'hA5A53C3C);

    // Timeout: prior key 0x12345678, then 10 beats and silence
    load_key(32'h12345678, ^32'h12345678, 0, 32'hA5A53C3C);
    expect_commit(32'h12345678);
    pulse_start();
    stream_bits(32'hFFFFFFFF, 10, 0, 32'h12345678);
    repeat (15) @(negedge clk);
    chk1("to_err_early", err, 1'b0);
    chk1("to_busy_early", busy, 1'b1);
    @(negedge clk);
    chk1("to_err", err, 1'b1);
    chk1("to_idle", busy, 1'b0);
    chk1("to_ready", s_ready, 1'b0);
    chk32("to_key", key_out, 32'h12345678);
    chk1("to_applied", key_applied, 1'b1);
    chk1("to_no_done", load_done, 1'b0);
    @(negedge clk);
    chk1("to_err_sticky", err, 1'b1);
    pulse_start();
    chk1("start_clears_err", err, 1'b0);
    chk1("start_busy", busy, 1'b1);
    do_zeroize();

`ifdef RLL_KEY_PARITY_EN
    // Parity: good parity commits, bad parity keeps the prior key
    load_key(32'h0000000F, 1'b0, 0, 32'h0);
    expect_commit(32'h0000000F);
    load_key(32'h0000000F, 1'b1, 0, 32'h0000000F);
    @(negedge clk);
    chk1("par_err", err, 1'b1);
    chk1("par_no_done", load_done, 1'b0);
    chk32("par_key", key_out, 32'h0000000F);
    chk1("par_applied", key_applied, 1'b1);
    do_zeroize();
`endif

    // Zeroize during beat 20, with load_start in the same cycle
    load_key(32'hFFFFFFFF, 1'b0, 0, 32'h0);
    expect_commit(32'hFFFFFFFF);
    pulse_start();
    stream_bits(32'hFFFFFFFF, 19, 0, 32'hFFFFFFFF);
    s_valid = 1'b1; s_bit = 1'b1; zeroize = 1'b1; load_start = 1'b1;
    @(negedge clk);
    s_valid = 1'b0; zeroize = 1'b0; load_start = 1'b0;
    chk32("zmid_key", key_out, 32'h0);
    chk1("zmid_applied", key_applied, 1'b0);
    chk1("zmid_ready", s_ready, 1'b0);
    chk1("zmid_busy", busy, 1'b0);
    chk1("zmid_done", load_done, 1'b0);
    @(negedge clk);
    chk1("zmid_start_ignored", busy, 1'b0);

    // Reset during beat 20
    load_key(32'hFFFFFFFF, 1'b0, 0, 32'h0);
    expect_commit(32'hFFFFFFFF);
    pulse_start();
    stream_bits(32'hFFFFFFFF, 19, 0, 32'hFFFFFFFF);
    s_valid = 1'b1; s_bit = 1'b1; rst_n = 1'b0;
    @(negedge clk);
    s_valid = 1'b0; rst_n = 1'b1;
    chk32("rmid_key", key_out, 32'h0);
    chk1("rmid_applied", key_applied, 1'b0);
    chk1("rmid_ready", s_ready, 1'b0);
    chk1("rmid_busy", busy, 1'b0);
    chk1("rmid_err", err, 1'b0);
    hold_ok = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (load_done !== 1'b0 || busy !== 1'b0) hold_ok = 1'b0;
    end
    chk1("rmid_no_done", hold_ok, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
